dmem_bus_arbiter: RTL

- Two-master round-robin arbiter and sequencer for the shared data-memory port.
- Master 0 is the CPU load/store path (AddressBus / DataBusOut / DataBusIn). Master 1 is a DMA or debug loader.
- Serialises requests into single-cycle memory strobes. Waits a fixed memory latency, then returns read data with a one-cycle grant/valid pulse.

---
 rtl/dmem_bus_arbiter_if.sv | 49 ++++
 rtl/dmem_bus_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave  : arbiter view (takes requests, drives grants and the memory strobes)
// master : environment view (requesters and memory model)
interface dmem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared data-memory port.
// Master 0 is the CPU load/store path, master 1 a DMA/debug loader. Each request
// becomes one single-cycle memory strobe; after MEM_LATENCY cycles the read data
// is captured and the winner gets a one-cycle grant pulse.
// Optional build macro DMEM_ARB_PERF_EN adds grant and master-1 stall counters.
module dmem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  dmem_bus_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] m0_gnt_cnt,
  output logic [31:0] m1_gnt_cnt,
  output logic [31:0] m1_stall_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state,      w_state_nxt;
  logic              r_ptr,        w_ptr_nxt;      // master that wins a tie
  logic              r_sel,        w_sel_nxt;      // owner of the transaction in flight
  logic              r_txn_we,     w_txn_we_nxt;
  logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic              r_mem_re,     w_mem_re_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic              r_m0_gnt,     w_m0_gnt_nxt;
  logic              r_m1_gnt,     w_m1_gnt_nxt;
  logic [DATA_W-1:0] r_m0_rdata,   w_m0_rdata_nxt;
  logic [DATA_W-1:0] r_m1_rdata,   w_m1_rdata_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              w_win;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_sel       <= 1'b0;
      r_txn_we    <= 1'b0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel       <= w_sel_nxt;
      r_txn_we    <= w_txn_we_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_m0_gnt    <= w_m0_gnt_nxt;
      r_m1_gnt    <= w_m1_gnt_nxt;
      r_m0_rdata  <= w_m0_rdata_nxt;
      r_m1_rdata  <= w_m1_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state, arbitration and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_sel_nxt       = r_sel;
    w_txn_we_nxt    = r_txn_we;
    w_cnt_nxt       = r_cnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_re_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_m0_gnt_nxt    = 1'b0;
    w_m1_gnt_nxt    = 1'b0;
    w_m0_rdata_nxt  = r_m0_rdata;
    w_m1_rdata_nxt  = r_m1_rdata;
    w_win           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          // a lone requester wins outright; a tie goes to the pointer
          w_win     = (bus.m0_req && bus.m1_req) ? r_ptr : bus.m1_req;
          w_sel_nxt = w_win;
          w_ptr_nxt = ~w_win;
          if (w_win) begin
            w_mem_addr_nxt  = bus.m1_addr;
            w_mem_wdata_nxt = bus.m1_wdata;
            w_txn_we_nxt    = bus.m1_we;
          end else begin
            w_mem_addr_nxt  = bus.m0_addr;
            w_mem_wdata_nxt = bus.m0_wdata;
            w_txn_we_nxt    = bus.m0_we;
          end
          w_mem_re_nxt = ~w_txn_we_nxt;
          w_mem_we_nxt = w_txn_we_nxt;
          w_state_nxt  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        w_cnt_nxt   = LAT_LOAD;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (r_cnt == '0) begin
          // this edge closes the MEM_LATENCY-th cycle after the strobe
          if (!r_txn_we) begin
            if (r_sel) w_m1_rdata_nxt = bus.mem_rdata;
            else       w_m0_rdata_nxt = bus.mem_rdata;
          end
          w_m0_gnt_nxt = ~r_sel;
          w_m1_gnt_nxt = r_sel;
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.m0_gnt    = r_m0_gnt;
  assign bus.m1_gnt    = r_m1_gnt;
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.busy      = r_busy;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_m0_gnt_cnt;
  logic [31:0] r_m1_gnt_cnt;
  logic [31:0] r_m1_stall_cnt;

  // Grant counters and master-1 stall counter, all free-running with wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m0_gnt_cnt   <= '0;
      r_m1_gnt_cnt   <= '0;
      r_m1_stall_cnt <= '0;
    end else begin
      if (r_m0_gnt) r_m0_gnt_cnt <= r_m0_gnt_cnt + 32'd1;
      if (r_m1_gnt) r_m1_gnt_cnt <= r_m1_gnt_cnt + 32'd1;
      if (bus.m1_req && !r_m1_gnt) r_m1_stall_cnt <= r_m1_stall_cnt + 32'd1;
    end
  end

  assign m0_gnt_cnt   = r_m0_gnt_cnt;
  assign m1_gnt_cnt   = r_m1_gnt_cnt;
  assign m1_stall_cnt = r_m1_stall_cnt;
`endif

  // Configuration and bus-protocol invariants
  a_latency_range: assert property (@(posedge clk) disable iff (!rst)
    (MEM_LATENCY >= 1) && (MEM_LATENCY <= 15))
    else $error("dmem_bus_arbiter: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst)
    !(r_mem_re && r_mem_we))
    else $error("dmem_bus_arbiter: mem_re and mem_we both high");

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst)
    !(r_m0_gnt && r_m1_gnt))
    else $error("dmem_bus_arbiter: both grants high");

endmodule
